// File: rtl/rv_icache_pkg.sv
// rv_icache_pkg: shared types and constants for the rv_icache instruction cache.
package rv_icache_pkg;
    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 4;
    typedef logic [LINE_BYTES*8-1:0] line_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} state_e;
endpackage

// File: rtl/rv_icache_if.sv
// rv_icache_if: fetch, refill, snoop and statistics signals of rv_icache.
interface rv_icache_if;
    import rv_icache_pkg::*;
    logic        w_req;
    logic [31:0] w_req_addr;
    logic        w_req_ready;
    logic        w_rsp_valid;
    line_t       w_rsp_data;
    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic        w_mem_gnt;
    logic        w_mem_rvalid;
    line_t       w_mem_rdata;
    logic        w_cache_invalidate;
    logic [31:0] w_cache_invalidate_address;
    logic        w_flush;
    logic [31:0] w_hit_cnt;
    logic [31:0] w_miss_cnt;

    modport slave (
        input  w_req, w_req_addr, w_mem_gnt, w_mem_rvalid, w_mem_rdata,
               w_cache_invalidate, w_cache_invalidate_address, w_flush,
        output w_req_ready, w_rsp_valid, w_rsp_data, w_mem_req, w_mem_addr,
               w_hit_cnt, w_miss_cnt
    );
    modport master (
        output w_req, w_req_addr, w_mem_gnt, w_mem_rvalid, w_mem_rdata,
               w_cache_invalidate, w_cache_invalidate_address, w_flush,
        input  w_req_ready, w_rsp_valid, w_rsp_data, w_mem_req, w_mem_addr,
               w_hit_cnt, w_miss_cnt
    );
endinterface

// File: rtl/rv_icache_array.sv
// rv_icache_array: direct-mapped tag/data store, one synchronous read port and one write port.
module rv_icache_array
    import rv_icache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int TAG_W = 22
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [$clog2(LINES)-1:0] rd_idx,
    output logic [TAG_W-1:0]         rd_tag,
    output line_t                    rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  line_t                    wr_data
);
    logic [TAG_W-1:0] tags [LINES];
    line_t            data [LINES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_tag  <= tags[rd_idx];
            rd_data <= data[rd_idx];
        end
    end
endmodule

// File: rtl/rv_icache.sv
// rv_icache: direct-mapped instruction cache with 1-cycle hits, single-line refill and snoop/flush.
// Define RV_ICACHE_STATS_EN to build the saturating hit/miss counters.
module rv_icache
    import rv_icache_pkg::*;
#(
    parameter int LINES   = 64,
    parameter int MHARTID = 0
) (
    input logic CLK,
    input logic RST_X,
    rv_icache_if.slave bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - OFFSET_W - IDX_W;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   snoop_tag_q [LINES];
    logic [31:OFFSET_W] line_q;
    logic               poison_q;
    logic               rsp_q;
    line_t              rsp_data_q;
    logic [TAG_W-1:0]   rd_tag;
    line_t              rd_data;
    logic [IDX_W-1:0]   cur_idx, inv_idx;
    logic [TAG_W-1:0]   cur_tag, inv_tag;
    logic               lookup, hit, accept, refill, inv_cur_line, inv_clear;
    logic [39:0]        unused;

    assign unused  = {32'(MHARTID), bus.w_req_addr[3:0], bus.w_cache_invalidate_address[3:0]};
    assign cur_idx = line_q[OFFSET_W+IDX_W-1:OFFSET_W];
    assign cur_tag = line_q[31:OFFSET_W+IDX_W];
    assign inv_idx = bus.w_cache_invalidate_address[OFFSET_W+IDX_W-1:OFFSET_W];
    assign inv_tag = bus.w_cache_invalidate_address[31:OFFSET_W+IDX_W];

    assign lookup = state_q == LOOKUP;
    assign hit    = lookup & valid_q[cur_idx] & (rd_tag == cur_tag) & !bus.w_flush
                  & !(bus.w_cache_invalidate & (inv_idx == cur_idx));
    assign bus.w_req_ready = RST_X & ((state_q == IDLE) | hit);
    assign accept = bus.w_req & bus.w_req_ready;
    assign refill = (state_q == MISS_WAIT) & bus.w_mem_rvalid;
    // Snoops compare against a flop copy of the tags so the array read port stays with the core.
    assign inv_cur_line = bus.w_cache_invalidate & (bus.w_cache_invalidate_address[31:OFFSET_W] == line_q);
    assign inv_clear    = bus.w_cache_invalidate & valid_q[inv_idx] & (snoop_tag_q[inv_idx] == inv_tag);

    assign bus.w_mem_req   = state_q == MISS_REQ;
    assign bus.w_mem_addr  = {line_q, {OFFSET_W{1'b0}}};
    assign bus.w_rsp_valid = rsp_q | hit;
    assign bus.w_rsp_data  = rsp_q ? rsp_data_q : (lookup ? rd_data : '0);

    rv_icache_array #(.LINES(LINES), .TAG_W(TAG_W)) u_array (
        .clk     (CLK),
        .rd_en   (accept),
        .rd_idx  (bus.w_req_addr[OFFSET_W+IDX_W-1:OFFSET_W]),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (refill & RST_X),
        .wr_idx  (cur_idx),
        .wr_tag  (cur_tag),
        .wr_data (bus.w_mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      state_d = accept ? LOOKUP : IDLE;
            LOOKUP:    state_d = !hit ? MISS_REQ : (bus.w_req ? LOOKUP : IDLE);
            MISS_REQ:  state_d = bus.w_mem_gnt ? MISS_WAIT : MISS_REQ;
            MISS_WAIT: state_d = bus.w_mem_rvalid ? IDLE : MISS_WAIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            line_q     <= '0;
            poison_q   <= 1'b0;
            rsp_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= refill;
            if (refill) rsp_data_q <= bus.w_mem_rdata;
            if (accept) line_q <= bus.w_req_addr[31:OFFSET_W];
            // A line flushed or snooped while its refill is in flight is delivered once but not kept.
            poison_q <= lookup ? 1'b0 : poison_q | (((state_q == MISS_REQ) | (state_q == MISS_WAIT))
                        & (bus.w_flush | inv_cur_line));
            if (bus.w_flush) valid_q <= '0;
            else begin
                if (inv_clear) valid_q[inv_idx] <= 1'b0;
                if (refill) valid_q[cur_idx] <= !(poison_q | inv_cur_line);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (refill & RST_X) snoop_tag_q[cur_idx] <= cur_tag;
    end

`ifdef RV_ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (lookup && !hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign bus.w_hit_cnt  = hit_cnt_q;
    assign bus.w_miss_cnt = miss_cnt_q;
`else
    assign bus.w_hit_cnt  = '0;
    assign bus.w_miss_cnt = '0;
`endif
endmodule

// File: tb/tb_rv_icache.sv
// tb_rv_icache: randomized scoreboard bench for rv_icache against a direct-mapped reference model.
module tb_rv_icache;
    localparam int LINES = 64;
`ifdef RV_ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_x = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_hit = 0;
    int   n_miss = 0;
    int   rv_cyc = 0;
    int   gnt_dly = 0;
    int   rv_dly = 0;
    bit   rnd_dly = 1'b0;
    bit   ref_valid [LINES];
    int   ref_tag [LINES];
    exp_t exp_rsp [$];
    logic [31:0] exp_mem [$];
    exp_t mon_e;

    rv_icache_if bus ();

    rv_icache #(.LINES(LINES), .MHARTID(0)) dut (
        .CLK   (clk),
        .RST_X (rst_x),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] mem_data(input logic [31:0] a);
        return {a, ~a, a ^ 32'h1234_5678, a[31:8] ^ 24'h5A_5A5A, 8'hA5};
    endfunction

    function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void fail(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s", nm);
    endfunction

    function automatic void model_clear();
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
    endfunction

    function automatic void model_snoop(input logic [31:0] a);
        int idx = int'((a / 16) % LINES);
        if (ref_valid[idx] && ref_tag[idx] == int'(a / (16 * LINES))) ref_valid[idx] = 1'b0;
    endfunction

    function automatic void predict(input logic [31:0] a, input int due);
        int idx = int'((a / 16) % LINES);
        int tag = int'(a / (16 * LINES));
        logic [31:0] line = a - (a % 16);
        bit h = ref_valid[idx] && ref_tag[idx] == tag;
        exp_rsp.push_back('{mem_data(line), h ? due : -1});
        if (h) n_hit++;
        else begin
            n_miss++;
            exp_mem.push_back(line);
            ref_valid[idx] = 1'b1;
            ref_tag[idx] = tag;
        end
    endfunction

    task automatic fetch(input logic [31:0] a, input bit fl);
        int n = 0;
        bus.w_req = 1'b1;
        bus.w_req_addr = a;
        @(negedge clk);
        while (!bus.w_req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.w_req_ready) begin
            $display("FAIL accept %0h: w_req_ready never seen", a);
            n_chk++;
            n_err++;
            bus.w_req = 1'b0;
            return;
        end
        if (fl) model_clear();
        predict(a, cyc + 1);
        @(posedge clk); #1;
        bus.w_req = 1'b0;
        if (fl) begin
            bus.w_flush = 1'b1;
            @(posedge clk); #1;
            bus.w_flush = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_rsp.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_rsp.size() != 0) begin
            fail("drain: responses outstanding after timeout");
            exp_rsp.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_mem(input bit want_rvalid);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(want_rvalid ? bus.w_mem_rvalid : bus.w_mem_gnt) && n < 100);
        if (!(want_rvalid ? bus.w_mem_rvalid : bus.w_mem_gnt)) fail("wait_mem: memory handshake timeout");
    endtask

    task automatic snoop(input logic [31:0] a);
        drain();
        bus.w_cache_invalidate = 1'b1;
        bus.w_cache_invalidate_address = a;
        model_snoop(a);
        @(posedge clk); #1;
        bus.w_cache_invalidate = 1'b0;
    endtask

    task automatic flush_all();
        drain();
        bus.w_flush = 1'b1;
        model_clear();
        @(posedge clk); #1;
        bus.w_flush = 1'b0;
    endtask

    task automatic check_cnt(input string nm);
        check({nm, " hit_cnt"}, 128'(bus.w_hit_cnt), 128'(STATS ? n_hit : 0));
        check({nm, " miss_cnt"}, 128'(bus.w_miss_cnt), 128'(STATS ? n_miss : 0));
    endtask

    // Memory: one refill at a time, grant and data after configurable or random delays.
    initial begin
        logic [31:0] a;
        int d;
        bus.w_mem_gnt = 1'b0;
        bus.w_mem_rvalid = 1'b0;
        bus.w_mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.w_mem_req) begin
                if (exp_mem.size() == 0) begin
                    $display("FAIL mem_req: unexpected refill of %0h", bus.w_mem_addr);
                    n_chk++;
                    n_err++;
                end else check("mem_addr", 128'(bus.w_mem_addr), 128'(exp_mem.pop_front()));
                d = rnd_dly ? int'($urandom_range(0, 3)) : gnt_dly;
                repeat (d) begin @(posedge clk); #1; end
                a = bus.w_mem_addr;
                bus.w_mem_gnt = 1'b1;
                @(posedge clk); #1;
                bus.w_mem_gnt = 1'b0;
                d = rnd_dly ? int'($urandom_range(0, 3)) : rv_dly;
                repeat (d) begin @(posedge clk); #1; end
                bus.w_mem_rvalid = 1'b1;
                bus.w_mem_rdata = mem_data(a);
                rv_cyc = cyc;
                @(posedge clk); #1;
                bus.w_mem_rvalid = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every response must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.w_rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    $display("FAIL rsp: unexpected response %0h", bus.w_rsp_data);
                    n_chk++;
                    n_err++;
                end else begin
                    mon_e = exp_rsp.pop_front();
                    check("rsp_data", bus.w_rsp_data, mon_e.data);
                    check("rsp_cycle", 128'(cyc), 128'(mon_e.due < 0 ? rv_cyc + 1 : mon_e.due));
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int r;
        bus.w_req = 1'b0;
        bus.w_req_addr = '0;
        bus.w_cache_invalidate = 1'b0;
        bus.w_cache_invalidate_address = '0;
        bus.w_flush = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", 128'(bus.w_req_ready), 128'(0));
        check("reset rsp_valid", 128'(bus.w_rsp_valid), 128'(0));
        check("reset rsp_data", bus.w_rsp_data, 128'(0));
        check("reset mem_req", 128'(bus.w_mem_req), 128'(0));
        check_cnt("reset");
        @(posedge clk); #1;
        rst_x = 1'b1;

        // Cold miss with grant after 3 cycles, then two back-to-back hits in the same line.
        gnt_dly = 3;
        rv_dly = 1;
        fetch(32'h8000_0010, 1'b0);
        drain();
        check_cnt("cold miss");
        fetch(32'h8000_001C, 1'b0);
        fetch(32'h8000_0014, 1'b0);
        drain();
        check_cnt("b2b hits");

        // Conflict eviction on the same index.
        fetch(32'h8000_0410, 1'b0);
        drain();
        fetch(32'h8000_0010, 1'b0);
        drain();

        // Snoop of the line while its refill is in flight.
        snoop(32'h8000_0010);
        gnt_dly = 1;
        rv_dly = 3;
        fetch(32'h8000_0010, 1'b0);
        wait_mem(1'b0);
        @(posedge clk); #1;
        bus.w_cache_invalidate = 1'b1;
        bus.w_cache_invalidate_address = 32'h8000_0010;
        model_snoop(32'h8000_0010);
        @(posedge clk); #1;
        bus.w_cache_invalidate = 1'b0;
        drain();
        fetch(32'h8000_0010, 1'b0);
        drain();

        // Flush during a lookup of a valid line.
        fetch(32'h8000_0020, 1'b0);
        fetch(32'h8000_0030, 1'b0);
        drain();
        fetch(32'h8000_0020, 1'b1);
        drain();
        fetch(32'h8000_0030, 1'b0);
        drain();

        // Refill write and a snoop of another index in the same cycle.
        fetch(32'h8000_0040, 1'b0);
        drain();
        fetch(32'h8000_0050, 1'b0);
        wait_mem(1'b1);
        bus.w_cache_invalidate = 1'b1;
        bus.w_cache_invalidate_address = 32'h8000_0048;
        model_snoop(32'h8000_0048);
        @(posedge clk); #1;
        bus.w_cache_invalidate = 1'b0;
        drain();
        fetch(32'h8000_0050, 1'b0);
        fetch(32'h8000_0040, 1'b0);
        drain();
        check_cnt("directed");

        // Random fetches over a small conflicting address pool with snoops and flushes.
        rnd_dly = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = 32'h8000_0000 + 32'($urandom_range(0, 2)) * 32'h400
              + 32'($urandom_range(0, 3)) * 32'h10 + 32'($urandom_range(0, 15));
            r = int'($urandom_range(0, 19));
            if (r < 16) fetch(a, 1'b0);
            else if (r < 19) snoop(a);
            else flush_all();
        end
        drain();
        check_cnt("random");

        // Reset in MISS_WAIT abandons the refill; the late rvalid must be ignored.
        rnd_dly = 1'b0;
        gnt_dly = 0;
        rv_dly = 3;
        fetch(32'h8000_0770, 1'b0);
        wait_mem(1'b0);
        @(posedge clk); #1;
        rst_x = 1'b0;
        exp_rsp.delete();
        model_clear();
        n_hit = 0;
        n_miss = 0;
        @(negedge clk);
        check("ready in reset", 128'(bus.w_req_ready), 128'(0));
        @(posedge clk); #1;
        rst_x = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post-reset rsp_valid", 128'(bus.w_rsp_valid), 128'(0));
        end
        check("post-reset mem_req", 128'(bus.w_mem_req), 128'(0));
        check("post-reset rsp_data", bus.w_rsp_data, 128'(0));
        check_cnt("post-reset");
        @(posedge clk); #1;
        fetch(32'h8000_0010, 1'b0);
        drain();

        check("rsp queue empty", 128'(exp_rsp.size()), 128'(0));
        check("mem queue empty", 128'(exp_mem.size()), 128'(0));
        check_cnt("final");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/rv_icache.md
RV_ICACHE -- requirements
Module: rv_icache

Interface
REQ-001 SHALL have parameter LINES, default 64, number of direct-mapped 128-bit lines (power of two, >=2).
REQ-002 SHALL have parameter MHARTID, default 0, hart id, for tracing only.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST_X  in  1  reset; one clock, synchronous, active-low.
REQ-005 w_req  in  1  core fetch request valid.
REQ-006 w_req_addr  in  32  fetch byte address; bits [3:0] ignored.
REQ-007 w_req_ready  out  1  request accepted when w_req&w_req_ready.
REQ-008 w_rsp_valid  out  1  one-cycle pulse, w_rsp_data valid.
REQ-009 w_rsp_data  out  128  aligned 16-byte line containing the requested address.
REQ-010 w_mem_req  out  1  refill request; held until granted.
REQ-011 w_mem_addr  out  32  refill line address, [3:0]=0.
REQ-012 w_mem_gnt  in  1  memory accepted w_mem_req.
REQ-013 w_mem_rvalid  in  1  refill data valid.
REQ-014 w_mem_rdata  in  128  refill line.
REQ-015 w_cache_invalidate  in  1  snoop invalidate strobe.
REQ-016 w_cache_invalidate_address  in  32  snooped line address.
REQ-017 w_flush  in  1  invalidate all lines (fence.i / satp change).
REQ-018 w_hit_cnt, w_miss_cnt  out  32 each  statistics counters.

Function
REQ-019 Index = addr[3+log2(LINES):4]; tag = addr[31:4+log2(LINES)]; per-line valid bits held in flops.
REQ-020 States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT.
REQ-021 w_req_ready SHALL be 1 in IDLE, and in LOOKUP only when the current lookup hits; 0 otherwise.
REQ-022 Accepted request in cycle N -> LOOKUP in N+1; hit -> w_rsp_valid=1 with line data in N+1 (1-cycle latency).
REQ-023 Hit in LOOKUP with a new request accepted -> remain LOOKUP (one hit per cycle); hit without request -> IDLE.
REQ-024 Hit = valid & tag match & !w_flush & !(w_cache_invalidate & invalidate index equals lookup index).
REQ-025 Miss in LOOKUP -> MISS_REQ next cycle; w_mem_req=1, w_mem_addr = line address; stays until w_mem_gnt, then MISS_WAIT.
REQ-026 MISS_WAIT: on w_mem_rvalid, write tag/data; w_rsp_valid=1 with w_mem_rdata next cycle; state -> IDLE.
REQ-027 w_mem_rvalid outside MISS_WAIT and w_mem_gnt outside MISS_REQ SHALL be ignored.
REQ-028 w_cache_invalidate clears the valid bit of the matching index when the tag matches, in the same edge.
REQ-029 w_flush clears all valid bits in one edge; flush has priority over a same-cycle refill write.
REQ-030 Flush or a matching invalidate during MISS_REQ/MISS_WAIT: refill still completes and data is returned to core, but the line is left invalid (poison flag).
REQ-031 A refill write and an invalidate to a different index in the same cycle SHALL both take effect.

Reset
REQ-032 RST_X=0 at an edge: state IDLE, all valid bits 0, w_mem_req 0, w_rsp_valid 0, w_rsp_data 0, counters 0, poison 0.
REQ-033 Reset during MISS_REQ/MISS_WAIT abandons the refill; later w_mem_rvalid is ignored per REQ-027.
REQ-034 w_req_ready SHALL be 0 while RST_X=0.

Configuration
REQ-035 With macro RV_ICACHE_STATS_EN defined, w_hit_cnt increments per hit, w_miss_cnt per miss in LOOKUP, both saturating at 0xFFFFFFFF.
REQ-036 Without RV_ICACHE_STATS_EN, the ports exist and are driven constant 0; no counter flops are synthesized.

Structure
REQ-037 Shared package rv_icache_pkg: state enum, LINE_BYTES=16, OFFSET_W=4, line data typedef (128 bits).
REQ-038 Tag/data storage SHALL be a single sub-module rv_icache_array (one read port, one write port, synchronous read); valid bits and FSM stay in rv_icache.

Verification
REQ-039 Cold fetch 0x8000_0010, memory grants after 3 cycles, rdata=0x...A5 -> w_mem_addr=0x8000_0010, w_rsp_valid one cycle after rvalid with 0x...A5, miss_cnt=1.
REQ-040 Refetch 0x8000_001C, then 0x8000_0014 back-to-back -> both hit, rsp in N+1 and N+2, no w_mem_req, hit_cnt=2.
REQ-041 LINES=64: fetch 0x8000_0010 then 0x8000_0410 (same index, different tag) -> second misses, evicts; refetch 0x8000_0010 misses.
REQ-042 Invalidate 0x8000_0010 during MISS_WAIT of that line -> data returned, next fetch of 0x8000_0010 misses.
REQ-043 w_flush in the same cycle as a LOOKUP on a valid line -> treated as miss, w_mem_req asserted; all lines invalid afterward.
REQ-044 RST_X=0 for one cycle in MISS_WAIT, then stray w_mem_rvalid -> no w_rsp_valid, all outputs at reset values, counters 0.
